// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Optional same-cycle update-to-lookup forwarding is enabled by defining BTB_BYPASS_EN.
module branch_target_buffer #(
    parameter int NUM_ENTRIES = 8,
    localparam int IDX_W = $clog2(NUM_ENTRIES),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] lookup_pc,
    output logic        branch_hit,
    output logic [29:0] target_address,
    output logic [1:0]  branch_history,
    output logic [31:0] pc_predicted,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [29:0] update_target
);

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    logic              valid_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]  tag_q    [NUM_ENTRIES];
    logic [29:0]       target_q [NUM_ENTRIES];
    logic [1:0]        ctr_q    [NUM_ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic              up_write;

    logic              nxt_valid;
    logic [TAG_W-1:0]  nxt_tag;
    logic [29:0]       nxt_target;
    logic [1:0]        nxt_ctr;

    logic              sel_valid;
    logic [TAG_W-1:0]  sel_tag;
    logic [29:0]       sel_target;
    logic [1:0]        sel_ctr;
    logic              hit;

    // Byte-offset bits of the update address carry no information for a word-aligned BTB.
    logic              unused_update_lsb;
    assign unused_update_lsb = ^update_pc[1:0];

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[31:IDX_W+2];

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        nxt_valid  = valid_q[up_idx];
        nxt_tag    = tag_q[up_idx];
        nxt_target = target_q[up_idx];
        nxt_ctr    = ctr_q[up_idx];
        up_write   = 1'b0;
        if (update_en) begin
            if (up_hit) begin
                up_write = 1'b1;
                if (update_taken) begin
                    nxt_ctr    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    nxt_target = update_target;
                end else begin
                    nxt_ctr    = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                end
            end else if (update_taken) begin
                // Allocation evicts whatever alias occupied this index.
                up_write   = 1'b1;
                nxt_valid  = 1'b1;
                nxt_tag    = up_tag;
                nxt_target = update_target;
                nxt_ctr    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (up_write) begin
            valid_q[up_idx]  <= nxt_valid;
            tag_q[up_idx]    <= nxt_tag;
            target_q[up_idx] <= nxt_target;
            ctr_q[up_idx]    <= nxt_ctr;
        end
    end

`ifdef BTB_BYPASS_EN
    logic fwd;
    // Full word-address match only; index-only collisions read the stored entry.
    assign fwd = nRST && update_en && (update_pc[31:2] == lookup_pc[31:2]);

    always_comb begin
        sel_valid  = valid_q[lk_idx];
        sel_tag    = tag_q[lk_idx];
        sel_target = target_q[lk_idx];
        sel_ctr    = ctr_q[lk_idx];
        if (fwd) begin
            sel_valid  = nxt_valid;
            sel_tag    = nxt_tag;
            sel_target = nxt_target;
            sel_ctr    = nxt_ctr;
        end
    end
`else
    always_comb begin
        sel_valid  = valid_q[lk_idx];
        sel_tag    = tag_q[lk_idx];
        sel_target = target_q[lk_idx];
        sel_ctr    = ctr_q[lk_idx];
    end
`endif

    assign hit = sel_valid && (sel_tag == lk_tag);

    always_comb begin
        branch_hit     = hit;
        target_address = 30'd0;
        branch_history = CTR_RESET;
        pc_predicted   = lookup_pc + 32'd4;
        if (hit) begin
            target_address = sel_target;
            branch_history = sel_ctr;
            if (sel_ctr[1]) begin
                pc_predicted = {sel_target, 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (NUM_ENTRIES=8).
// Same-cycle expectations follow BTB_BYPASS_EN when it is defined for the build.
module tb_branch_target_buffer;

    logic        CLK;
    logic        nRST;
    logic [31:0] lookup_pc;
    logic        branch_hit;
    logic [29:0] target_address;
    logic [1:0]  branch_history;
    logic [31:0] pc_predicted;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [29:0] update_target;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_buffer #(.NUM_ENTRIES(8)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .lookup_pc      (lookup_pc),
        .branch_hit     (branch_hit),
        .target_address (target_address),
        .branch_history (branch_history),
        .pc_predicted   (pc_predicted),
        .update_en      (update_en),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_target  (update_target)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic do_update(input logic [31:0] pc, input logic taken, input logic [29:0] tgt);
        update_en     = 1'b1;
        update_pc     = pc;
        update_taken  = taken;
        update_target = tgt;
        @(posedge CLK);
        #1;
        update_en = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        look(32'h40);
        n_checks++; if (branch_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", branch_hit); end
        n_checks++; if (branch_history !== 2'b01) begin n_fail++; $display("FAIL reset_hist got %b want 01", branch_history); end
        n_checks++; if (target_address !== 30'd0) begin n_fail++; $display("FAIL reset_target got %h want 0", target_address); end
        n_checks++; if (pc_predicted !== 32'h44) begin n_fail++; $display("FAIL reset_pred got %h want 44", pc_predicted); end
        look(32'hFFFF_FFFC);
        n_checks++; if (pc_predicted !== 32'h0) begin n_fail++; $display("FAIL wrap_pred got %h want 0", pc_predicted); end
    endtask

    task automatic test_allocate();
        do_update(32'h40, 1'b1, 30'h40);
        look(32'h40);
        n_checks++; if (branch_hit !== 1'b1) begin n_fail++; $display("FAIL alloc_hit got %b want 1", branch_hit); end
        n_checks++; if (branch_history !== 2'b10) begin n_fail++; $display("FAIL alloc_hist got %b want 10", branch_history); end
        n_checks++; if (target_address !== 30'h40) begin n_fail++; $display("FAIL alloc_target got %h want 40", target_address); end
        n_checks++; if (pc_predicted !== 32'h100) begin n_fail++; $display("FAIL alloc_pred got %h want 100", pc_predicted); end
        look(32'h43);
        n_checks++; if (pc_predicted !== 32'h100) begin n_fail++; $display("FAIL alloc_lsb_pred got %h want 100", pc_predicted); end
        look(32'h44);
        n_checks++; if (branch_hit !== 1'b0) begin n_fail++; $display("FAIL neighbour_hit got %b want 0", branch_hit); end
    endtask

    task automatic test_saturate();
        logic [1:0]  exp_hist [7];
        logic [31:0] exp_pred [7];
        exp_hist = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        exp_pred = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h44, 32'h44, 32'h44};
        for (int i = 0; i < 7; i++) begin
            do_update(32'h40, (i < 3), 30'h40);
            look(32'h40);
            n_checks++; if (branch_hit !== 1'b1) begin n_fail++; $display("FAIL sat_hit[%0d] got %b want 1", i, branch_hit); end
            n_checks++; if (branch_history !== exp_hist[i]) begin n_fail++; $display("FAIL sat_hist[%0d] got %b want %b", i, branch_history, exp_hist[i]); end
            n_checks++; if (pc_predicted !== exp_pred[i]) begin n_fail++; $display("FAIL sat_pred[%0d] got %h want %h", i, pc_predicted, exp_pred[i]); end
        end
        n_checks++; if (target_address !== 30'h40) begin n_fail++; $display("FAIL nt_keeps_target got %h want 40", target_address); end
    endtask

    task automatic test_retarget();
        do_update(32'h40, 1'b1, 30'h50);
        look(32'h40);
        n_checks++; if (branch_history !== 2'b01) begin n_fail++; $display("FAIL retarget_hist got %b want 01", branch_history); end
        n_checks++; if (target_address !== 30'h50) begin n_fail++; $display("FAIL retarget_target got %h want 50", target_address); end
        n_checks++; if (pc_predicted !== 32'h44) begin n_fail++; $display("FAIL retarget_pred got %h want 44", pc_predicted); end
        do_update(32'h40, 1'b1, 30'h50);
        look(32'h40);
        n_checks++; if (pc_predicted !== 32'h140) begin n_fail++; $display("FAIL retarget_pred2 got %h want 140", pc_predicted); end
        // update_en low with other update inputs active must leave the table alone
        update_pc = 32'h40; update_taken = 1'b0; update_target = 30'h3;
        @(posedge CLK); #1;
        look(32'h40);
        n_checks++; if (branch_history !== 2'b10) begin n_fail++; $display("FAIL hold_hist got %b want 10", branch_history); end
    endtask

    task automatic test_alias();
        look(32'h60);
        n_checks++; if (branch_hit !== 1'b0) begin n_fail++; $display("FAIL alias_miss got %b want 0", branch_hit); end
        do_update(32'h60, 1'b0, 30'h80);
        look(32'h40);
        n_checks++; if (branch_hit !== 1'b1) begin n_fail++; $display("FAIL alias_nt_keep got %b want 1", branch_hit); end
        look(32'h60);
        n_checks++; if (branch_hit !== 1'b0) begin n_fail++; $display("FAIL alias_nt_noalloc got %b want 0", branch_hit); end
        do_update(32'h60, 1'b1, 30'h80);
        look(32'h60);
        n_checks++; if (branch_hit !== 1'b1) begin n_fail++; $display("FAIL alias_alloc_hit got %b want 1", branch_hit); end
        n_checks++; if (pc_predicted !== 32'h200) begin n_fail++; $display("FAIL alias_alloc_pred got %h want 200", pc_predicted); end
        n_checks++; if (branch_history !== 2'b10) begin n_fail++; $display("FAIL alias_alloc_hist got %b want 10", branch_history); end
        look(32'h40);
        n_checks++; if (branch_hit !== 1'b0) begin n_fail++; $display("FAIL alias_evict got %b want 0", branch_hit); end
    endtask

    task automatic test_same_cycle();
        logic        exp_hit;
        logic [31:0] exp_pred;
        logic [1:0]  exp_hist;
`ifdef BTB_BYPASS_EN
        exp_hit = 1'b1; exp_pred = 32'h100; exp_hist = 2'b10;
`else
        exp_hit = 1'b0; exp_pred = 32'h44;  exp_hist = 2'b01;
`endif
        nRST = 1'b0; #1; nRST = 1'b1;
        update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1; update_target = 30'h40;
        look(32'h40);
        n_checks++; if (branch_hit !== exp_hit) begin n_fail++; $display("FAIL same_hit got %b want %b", branch_hit, exp_hit); end
        n_checks++; if (pc_predicted !== exp_pred) begin n_fail++; $display("FAIL same_pred got %h want %h", pc_predicted, exp_pred); end
        n_checks++; if (branch_history !== exp_hist) begin n_fail++; $display("FAIL same_hist got %b want %b", branch_history, exp_hist); end
        @(posedge CLK); #1;
        update_en = 1'b0;
        look(32'h40);
        n_checks++; if (branch_hit !== 1'b1) begin n_fail++; $display("FAIL same_next_hit got %b want 1", branch_hit); end
        // index collision with a different tag is never forwarded
        update_en = 1'b1; update_pc = 32'h60; update_taken = 1'b1; update_target = 30'h80;
        look(32'h40);
        n_checks++; if (pc_predicted !== 32'h100) begin n_fail++; $display("FAIL collide_pred got %h want 100", pc_predicted); end
        @(posedge CLK); #1;
        update_en = 1'b0;
        look(32'h40);
        n_checks++; if (branch_hit !== 1'b0) begin n_fail++; $display("FAIL collide_evict got %b want 0", branch_hit); end
        // not-taken to an empty entry still reports a miss even when addresses match
        update_en = 1'b1; update_pc = 32'h48; update_taken = 1'b0; update_target = 30'h1;
        look(32'h48);
        n_checks++; if (branch_hit !== 1'b0) begin n_fail++; $display("FAIL same_nt_miss got %b want 0", branch_hit); end
        @(posedge CLK); #1;
        update_en = 1'b0;
    endtask

    task automatic test_async_reset();
        do_update(32'h40, 1'b1, 30'h40);
        look(32'h40);
        n_checks++; if (branch_hit !== 1'b1) begin n_fail++; $display("FAIL pre_rst_hit got %b want 1", branch_hit); end
        nRST = 1'b0;
        #1;
        n_checks++; if (branch_hit !== 1'b0) begin n_fail++; $display("FAIL async_hit got %b want 0", branch_hit); end
        n_checks++; if (branch_history !== 2'b01) begin n_fail++; $display("FAIL async_hist got %b want 01", branch_history); end
        n_checks++; if (pc_predicted !== 32'h44) begin n_fail++; $display("FAIL async_pred got %h want 44", pc_predicted); end
        update_en = 1'b1; update_pc = 32'h80; update_taken = 1'b1; update_target = 30'h7;
        @(posedge CLK); #1;
        update_en = 1'b0;
        nRST = 1'b1;
        look(32'h40);
        n_checks++; if (branch_hit !== 1'b0) begin n_fail++; $display("FAIL post_rst_hit got %b want 0", branch_hit); end
        look(32'h80);
        n_checks++; if (branch_hit !== 1'b0) begin n_fail++; $display("FAIL dropped_update got %b want 0", branch_hit); end
    endtask

    initial begin
        nRST          = 1'b1;
        lookup_pc     = 32'h0;
        update_en     = 1'b0;
        update_pc     = 32'h0;
        update_taken  = 1'b0;
        update_target = 30'h0;
        #1;
        test_reset();
        test_allocate();
        test_saturate();
        test_retarget();
        test_alias();
        test_same_cycle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
